// File: rtl/booth_seq_mult_if.sv
// Handshake bundle for the sequential Booth multiplier: operands and start
// in, busy/done/product out.
interface booth_seq_mult_if #(parameter int N = 10);
  logic                    start;
  logic signed [N-1:0]     mcand;
  logic signed [N-1:0]     mplier;
  logic                    busy;
  logic                    done;
  logic signed [2*N-1:0]   product;

  modport master (output start, output mcand, output mplier,
                  input busy, input done, input product);
  modport slave  (input start, input mcand, input mplier,
                  output busy, output done, output product);
endinterface

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: one add/subtract-and-shift step per
// clock, N steps per signed N x N -> 2N product, start/busy/done handshake.
module booth_seq_mult #(
  parameter int N = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  booth_seq_mult_if.slave bus
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_r;
  logic signed [N:0]     a_r;
  logic signed [N:0]     m_r;
  logic [N-1:0]          q_r;
  logic                  qm1_r;
  logic [CW-1:0]         count_r;

  logic signed [N:0]     a_sum_s;
  logic signed [N:0]     a_next_s;
  logic [N-1:0]          q_next_s;

  // Booth add/subtract chosen by {Q[0],Q_m1}, then arithmetic shift of {A,Q}
  always_comb begin
    a_sum_s = a_r;
    case ({q_r[0], qm1_r})
      2'b01:   a_sum_s = a_r + m_r;
      2'b10:   a_sum_s = a_r - m_r;
      default: a_sum_s = a_r;
    endcase
    a_next_s = {a_sum_s[N], a_sum_s[N:1]};
    q_next_s = {a_sum_s[0], q_r[N-1:1]};
  end

  // Control FSM, datapath registers and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_r         <= (N+1)'(0);
      m_r         <= (N+1)'(0);
      q_r         <= N'(0);
      qm1_r       <= 1'b0;
      count_r     <= CW'(0);
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.product <= (2*N)'(0);
    end else begin
      case (state_r)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_r      <= (N+1)'(0);
            q_r      <= bus.mplier;
            qm1_r    <= 1'b0;
            // Extra sign bit keeps -M exact for the most negative operand
            m_r      <= {bus.mcand[N-1], bus.mcand};
            count_r  <= CW'(N);
            bus.busy <= 1'b1;
            state_r  <= RUN;
          end else begin
            state_r  <= IDLE;
          end
        end
        RUN: begin
          a_r     <= a_next_s;
          q_r     <= q_next_s;
          qm1_r   <= q_r[0];
          count_r <= count_r - CW'(1);
          if (count_r == CW'(1)) begin
            state_r     <= DONE;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            bus.product <= {a_next_s[N-1:0], q_next_s};
          end else begin
            state_r     <= RUN;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult: vector table, protocol corner
// sequences and random operands, with a queue-based scoreboard on done.
module tb_booth_seq_mult;
  localparam int N = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth_seq_mult_if #(.N(N)) bus ();
  booth_seq_mult #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int                    mc;
    int                    mp;
    logic signed [2*N-1:0] exp;
  } vec_t;

  vec_t                  tbl[10];
  logic signed [2*N-1:0] exp_q[$];
  logic signed [2*N-1:0] last_exp;
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int start_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every done pops one expected product
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done: got product %0d expected no done", bus.product);
      end else begin
        check("product", longint'(bus.product), longint'(exp_q.pop_front()));
        check("busy_during_done", longint'(bus.busy), 64'sd0);
      end
    end
  end

  // One multiply: wait gap cycles, pulse start, optionally pulse a stray
  // start during RUN, then measure the busy run up to done.
  task automatic run_op(input int mc, input int mp, input logic signed [2*N-1:0] exp,
                        input int gap, input int glitch_at);
    int busy_len;
    int t;
    repeat (gap) @(negedge clk);
    bus.mcand  = N'(mc);
    bus.mplier = N'(mp);
    bus.start  = 1'b1;
    exp_q.push_back(exp);
    start_cnt++;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.mcand  = N'($urandom);
    bus.mplier = N'($urandom);
    check("hold_prev_product", longint'(bus.product), longint'(last_exp));
    busy_len = 0;
    t = 0;
    while (!bus.done && t < 4*N) begin
      if (bus.busy) busy_len++;
      if (t == glitch_at) begin
        bus.start  = 1'b1;
        bus.mcand  = N'(37);
        bus.mplier = N'(-3);
      end else begin
        bus.start  = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    bus.start = 1'b0;
    check("done_seen", longint'(bus.done), 64'sd1);
    check("busy_len", longint'(busy_len), longint'(N));
    last_exp = exp;
  endtask

  initial begin
    tbl[0] = '{0, 0, 20'sd0};
    tbl[1] = '{-4, 14, -20'sd56};
    tbl[2] = '{218, 100, 20'sd21800};
    tbl[3] = '{-100, -400, 20'sd40000};
    tbl[4] = '{-512, -512, 20'sd262144};
    tbl[5] = '{-512, 511, -20'sd261632};
    tbl[6] = '{511, 511, 20'sd261121};
    tbl[7] = '{1, -1, -20'sd1};
    tbl[8] = '{-1, -1, 20'sd1};
    tbl[9] = '{511, -512, -20'sd261632};

    bus.start  = 1'b0;
    bus.mcand  = N'(0);
    bus.mplier = N'(0);
    last_exp   = 20'sd0;
    #1;
    check("reset_busy", longint'(bus.busy), 64'sd0);
    check("reset_done", longint'(bus.done), 64'sd0);
    check("reset_product", longint'(bus.product), 64'sd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table vectors; entries 2->3 run back-to-back (gap of one cycle)
    for (int i = 0; i < 10; i++)
      run_op(tbl[i].mc, tbl[i].mp, tbl[i].exp, (i == 3) ? 1 : 2, -1);

    // Stray start during RUN cycle 3 must be ignored
    run_op(-77, 91, -20'sd7007, 2, 2);
    repeat (3) begin
      @(negedge clk);
      check("no_restart_busy", longint'(bus.busy), 64'sd0);
    end

    // Reset in the middle of RUN discards the operation
    @(negedge clk);
    bus.mcand  = N'(123);
    bus.mplier = N'(-45);
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_busy", longint'(bus.busy), 64'sd1);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_busy", longint'(bus.busy), 64'sd0);
    check("midrun_reset_done", longint'(bus.done), 64'sd0);
    check("midrun_reset_product", longint'(bus.product), 64'sd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_exp = 20'sd0;
    repeat (2*N) @(negedge clk);
    check("no_done_after_reset", longint'(done_cnt), longint'(start_cnt));

    run_op(-300, 250, -20'sd75000, 1, -1);

    // Random operands with random idle gaps
    for (int i = 0; i < 1000; i++) begin
      int mc;
      int mp;
      logic signed [2*N-1:0] e;
      mc = int'($urandom_range(0, 1023)) - 512;
      mp = int'($urandom_range(0, 1023)) - 512;
      e  = (2*N)'(mc * mp);
      run_op(mc, mp, e, int'($urandom_range(1, 3)), -1);
    end

    repeat (4) @(negedge clk);
    check("done_count", longint'(done_cnt), longint'(start_cnt));
    check("queue_empty", longint'(exp_q.size()), 64'sd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
